// File: rtl/bsg_tx_sequencer_if.sv
// Bus bundle between the TX sequencer, its byte producer and the BSG register port.
//   in_data/in_valid/in_ready : producer push handshake into the sequencer FIFO
//   bus_addr/bus_wdata/bus_we : BSG register access (bus_we=0 write, 1 read/idle)
//   bus_rdata                 : BSG Data_out, valid the cycle after a read address
//   bsg_int                   : BSG_INT level
// master = sequencer side, slave = producer/BSG side.
interface bsg_tx_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_we;
  logic       bsg_int;

  modport master (
    input  in_data, in_valid, bus_rdata, bsg_int,
    output in_ready, bus_addr, bus_wdata, bus_we
  );

  modport slave (
    output in_data, in_valid, bus_rdata, bsg_int,
    input  in_ready, bus_addr, bus_wdata, bus_we
  );
endinterface

// File: rtl/bsg_tx_sequencer.sv
// Register-bus master feeding the BSG block from a byte FIFO. Bytes are loaded
// in pairs into BSG_DATA_0/1, BSG_CONTROL is armed (TXEN|INTMSK), and each
// interrupt either refills the next pair or disables TX when drained/stopped.
// Ports:
//   SYS_CLK    : clock, rising edge
//   rst        : asynchronous reset, active-high
//   bus        : producer handshake + BSG register bus (master modport)
//   stop       : level, graceful stop request (sampled in IDLE/RD_WAIT only)
//   busy       : state != IDLE
//   pair_count : pairs armed since reset, wraps
//   ctrl_snap  : last BSG_CONTROL value read
module bsg_tx_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter logic [7:0]  ADDR_CTRL  = 8'h00,
  parameter logic [7:0]  ADDR_DATA0 = 8'h01,
  parameter logic [7:0]  ADDR_DATA1 = 8'h02
) (
  input  logic                       SYS_CLK,
  input  logic                       rst,
  bsg_tx_sequencer_if.master         bus,
  input  logic                       stop,
  output logic                       busy,
  output logic [15:0]                pair_count,
  output logic [7:0]                 ctrl_snap
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [3:0] {
    IDLE, LOAD0, LOAD1, ARM, SETTLE, WAIT_INT, RD_CTRL, RD_WAIT, STOP
  } state_t;

  state_t        state, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_d;
  logic [AW:0]   count;
  logic          push, pop, have_pair;
  logic          we_d;
  logic [7:0]    addr_d, wdata_d;

  assign bus.in_ready = (count < (AW+1)'(DEPTH));
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = (state == LOAD0) || (state == LOAD1);
  assign rd_ptr_d     = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign have_pair    = (count >= (AW+1)'(2));
  assign busy         = (state != IDLE);

  always_ff @(posedge SYS_CLK) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge SYS_CLK or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_d;
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Bus outputs are registered from the next state, so the values appear
  // during the cycle the FSM occupies that state. Data comes from the head
  // pointer after this cycle's pop, i.e. the byte the next state will consume.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (have_pair && !stop) state_d = LOAD0;
      LOAD0:    state_d = LOAD1;
      LOAD1:    state_d = ARM;
      ARM:      state_d = SETTLE;
      SETTLE:   state_d = WAIT_INT;
      WAIT_INT: if (bus.bsg_int) state_d = RD_CTRL;
      RD_CTRL:  state_d = RD_WAIT;
      RD_WAIT: begin
        if (!bus.bus_rdata[2])        state_d = WAIT_INT;
        else if (have_pair && !stop)  state_d = LOAD0;
        else                          state_d = STOP;
      end
      STOP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    we_d    = 1'b1;
    addr_d  = ADDR_CTRL;
    wdata_d = '0;
    case (state_d)
      LOAD0: begin
        we_d    = 1'b0;
        addr_d  = ADDR_DATA0;
        wdata_d = mem[rd_ptr_d];
      end
      LOAD1: begin
        we_d    = 1'b0;
        addr_d  = ADDR_DATA1;
        wdata_d = mem[rd_ptr_d];
      end
      ARM: begin
        we_d    = 1'b0;
        wdata_d = 8'h03;
      end
      STOP: begin
        we_d    = 1'b0;
        wdata_d = 8'h00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge SYS_CLK or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.bus_we    <= 1'b1;
      bus.bus_addr  <= ADDR_CTRL;
      bus.bus_wdata <= '0;
      pair_count    <= '0;
      ctrl_snap     <= '0;
    end else begin
      state         <= state_d;
      bus.bus_we    <= we_d;
      bus.bus_addr  <= addr_d;
      bus.bus_wdata <= wdata_d;
      if (state == ARM)     pair_count <= pair_count + 16'd1;
      if (state == RD_WAIT) ctrl_snap  <= bus.bus_rdata;
    end
  end

endmodule

// File: tb/tb_bsg_tx_sequencer.sv
// Directed bench for bsg_tx_sequencer: pair loading, refill on interrupt,
// spurious interrupt, full FIFO, graceful stop, async reset mid-operation.
module tb_bsg_tx_sequencer;

  logic        SYS_CLK;
  logic        rst;
  logic        stop;
  logic        busy;
  logic [15:0] pair_count;
  logic [7:0]  ctrl_snap;
  int          n_pass;
  int          n_total;

  bsg_tx_sequencer_if ifc ();

  bsg_tx_sequencer #(
    .DEPTH      (8),
    .ADDR_CTRL  (8'h00),
    .ADDR_DATA0 (8'h01),
    .ADDR_DATA1 (8'h02)
  ) dut (
    .SYS_CLK    (SYS_CLK),
    .rst        (rst),
    .bus        (ifc),
    .stop       (stop),
    .busy       (busy),
    .pair_count (pair_count),
    .ctrl_snap  (ctrl_snap)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_bus(input string tag, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata);
    chk({tag, "_we"},    16'(ifc.bus_we),    16'(we));
    chk({tag, "_addr"},  16'(ifc.bus_addr),  16'(addr));
    chk({tag, "_wdata"}, 16'(ifc.bus_wdata), 16'(wdata));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_we"},   16'(ifc.bus_we),   16'(1'b1));
    chk({tag, "_addr"}, 16'(ifc.bus_addr), 16'(8'h00));
  endtask

  task automatic push_byte(input logic [7:0] b);
    ifc.in_valid = 1'b1;
    ifc.in_data  = b;
    tick();
    ifc.in_valid = 1'b0;
  endtask

  // Three back-to-back writes, then SETTLE and WAIT_INT idle cycles.
  task automatic expect_pair(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [15:0] pc);
    tick(); chk_bus({tag, "_load0"}, 1'b0, 8'h01, b0);
    tick(); chk_bus({tag, "_load1"}, 1'b0, 8'h02, b1);
    tick(); chk_bus({tag, "_arm"},   1'b0, 8'h00, 8'h03);
    tick(); chk_idle({tag, "_settle"});
    chk({tag, "_pair_count"}, pair_count, pc);
    tick(); chk_idle({tag, "_wait"});
    chk({tag, "_busy"}, 16'(busy), 16'(1'b1));
  endtask

  // Raise the interrupt from WAIT_INT; leaves the FSM having just left RD_WAIT on the next tick.
  task automatic do_int(input string tag, input logic [7:0] rdata);
    ifc.bsg_int   = 1'b1;
    ifc.bus_rdata = rdata;
    tick(); chk_idle({tag, "_rdctrl"});
    ifc.bsg_int = 1'b0;
    tick(); chk_idle({tag, "_rdwait"});
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst           = 1'b1;
    stop          = 1'b0;
    ifc.in_data   = 8'h00;
    ifc.in_valid  = 1'b0;
    ifc.bus_rdata = 8'h00;
    ifc.bsg_int   = 1'b0;
    tick();
    tick();
    chk("rst_busy",       16'(busy),         16'(1'b0));
    chk("rst_in_ready",   16'(ifc.in_ready), 16'(1'b1));
    chk("rst_pair_count", pair_count,        16'h0000);
    chk("rst_ctrl_snap",  16'(ctrl_snap),    16'h0000);
    chk_bus("rst_bus", 1'b1, 8'h00, 8'h00);
    rst = 1'b0;
    tick();

    // First pair: three consecutive writes.
    push_byte(8'hA5);
    chk("one_byte_busy", 16'(busy), 16'(1'b0));
    push_byte(8'h3C);
    expect_pair("p1", 8'hA5, 8'h3C, 16'd1);

    // Spurious interrupt: INTFLAG clear in the readback.
    do_int("spur", 8'h03);
    tick(); chk_idle("spur_back");
    chk("spur_snap", 16'(ctrl_snap), 16'h0003);
    chk("spur_busy", 16'(busy), 16'(1'b1));
    tick(); chk_idle("spur_wait2");
    chk("spur_pair_count", pair_count, 16'd1);

    // Refill: four bytes queued while waiting, two interrupts load them.
    push_byte(8'h11); chk_idle("refill_push0");
    push_byte(8'h22); chk_idle("refill_push1");
    push_byte(8'h33); chk_idle("refill_push2");
    push_byte(8'h44); chk_idle("refill_push3");
    do_int("ref1", 8'h07);
    expect_pair("p2", 8'h11, 8'h22, 16'd2);
    chk("ref1_snap", 16'(ctrl_snap), 16'h0007);
    do_int("ref2", 8'h07);
    expect_pair("p3", 8'h33, 8'h44, 16'd3);
    do_int("drain", 8'h07);
    tick(); chk_bus("drain_stop", 1'b0, 8'h00, 8'h00);
    tick(); chk_idle("drain_idle");
    chk("drain_busy", 16'(busy), 16'(1'b0));

    // Full FIFO with loading held off by stop; the ninth byte must be dropped.
    stop = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("full_ready%0d", i), 16'(ifc.in_ready), 16'(i < 8));
      push_byte((i < 8) ? 8'(8'h80 + i) : 8'hEE);
      chk($sformatf("full_busy%0d", i), 16'(busy), 16'(1'b0));
    end
    chk("full_ready_end", 16'(ifc.in_ready), 16'(1'b0));
    stop = 1'b0;
    expect_pair("p4", 8'h80, 8'h81, 16'd4);
    chk("after_pop_ready", 16'(ifc.in_ready), 16'(1'b1));
    do_int("f5", 8'h07);
    expect_pair("p5", 8'h82, 8'h83, 16'd5);
    do_int("f6", 8'h07);
    expect_pair("p6", 8'h84, 8'h85, 16'd6);

    // Stop raised while waiting with two bytes queued.
    stop = 1'b1;
    do_int("stop", 8'h07);
    tick(); chk_bus("stop_write", 1'b0, 8'h00, 8'h00);
    tick(); chk_idle("stop_idle");
    chk("stop_busy", 16'(busy), 16'(1'b0));
    tick(); chk("stop_busy2", 16'(busy), 16'(1'b0));
    stop = 1'b0;
    expect_pair("p7", 8'h86, 8'h87, 16'd7);

    // Async reset mid-WAIT_INT with three bytes queued.
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy",       16'(busy),         16'(1'b0));
    chk("arst_we",         16'(ifc.bus_we),   16'(1'b1));
    chk("arst_in_ready",   16'(ifc.in_ready), 16'(1'b1));
    chk("arst_pair_count", pair_count,        16'h0000);
    chk("arst_ctrl_snap",  16'(ctrl_snap),    16'h0000);
    chk("arst_addr",       16'(ifc.bus_addr), 16'h0000);
    tick();
    rst = 1'b0;

    // Single leftover byte must wait for a partner.
    push_byte(8'h55);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("odd_busy%0d", i), 16'(busy), 16'(1'b0));
      chk_idle($sformatf("odd_idle%0d", i));
    end
    push_byte(8'h66);
    expect_pair("p8", 8'h55, 8'h66, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
